en_delay_line: RTL and testbench

EN_DELAY_LINE -- requirements
Module: en_delay_line

---
 rtl/en_dly_pkg.sv | 19 +
 rtl/en_reg.sv | 31 +++
 rtl/en_delay_line.sv | 95 +++++++++
 tb/tb_en_delay_line.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/en_dly_pkg.sv
// +--------------------------------------------------------------------+
// | en_dly_pkg : shared defaults and sizing helper for en_delay_line   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package en_dly_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  // DEPTH samples of WIDTH bits need log2(DEPTH) extra bits to never overflow.
  function automatic int sum_width(input int width, input int depth);
    return width + $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/en_reg.sv
// +--------------------------------------------------------------------+
// | en_reg : WIDTH-bit register, synchronous clear over enable         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module en_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/en_delay_line.sv
// +--------------------------------------------------------------------+
// | en_delay_line : enabled shift delay line with tap, sum and fill    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module en_delay_line
  import en_dly_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                                 clk,
  input  logic                                 CLR,
  input  logic                                 EN,
  input  logic                                 FLUSH,
  input  logic [WIDTH-1:0]                     D,
  input  logic [$clog2(DEPTH)-1:0]             TAP_SEL,
  output logic [WIDTH-1:0]                     Q,
  output logic [WIDTH-1:0]                     TAP,
  output logic [sum_width(WIDTH, DEPTH)-1:0]   SUM,
  output logic [$clog2(DEPTH+1)-1:0]           FILL,
  output logic                                 VLD
);

  localparam int SEL_W  = $clog2(DEPTH);
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam int SUM_W  = sum_width(WIDTH, DEPTH);

  logic [WIDTH-1:0]        w_stage [DEPTH];
  logic                    w_clr;
  logic signed [SUM_W-1:0] w_d_ext;
  logic signed [SUM_W-1:0] w_old_ext;
  logic signed [SUM_W-1:0] r_sum;
  logic [FILL_W-1:0]       r_fill;

  // Flush reuses the stage clear; CLR and FLUSH have identical effect on data.
  assign w_clr = CLR | FLUSH;

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
        en_reg #(.WIDTH(WIDTH)) u_reg (
          .clk (clk),
          .clr (w_clr),
          .en  (EN),
          .d   (D),
          .q   (w_stage[k])
        );
      end else begin : g_body
        en_reg #(.WIDTH(WIDTH)) u_reg (
          .clk (clk),
          .clr (w_clr),
          .en  (EN),
          .d   (w_stage[k-1]),
          .q   (w_stage[k])
        );
      end
    end
  endgenerate

  assign w_d_ext   = SUM_W'($signed(D));
  assign w_old_ext = SUM_W'($signed(w_stage[DEPTH-1]));

  // Add the incoming sample and retire the one falling off the end.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_sum  <= '0;
      r_fill <= '0;
    end else if (EN) begin
      r_sum <= r_sum + w_d_ext - w_old_ext;
      if (r_fill != FILL_W'(DEPTH)) begin
        r_fill <= r_fill + FILL_W'(1);
      end
    end
  end

  // Indices at or beyond DEPTH match no stage and read as zero.
  always_comb begin
    TAP = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (TAP_SEL == SEL_W'(k)) begin
        TAP = w_stage[k];
      end
    end
  end

  assign Q    = w_stage[DEPTH-1];
  assign SUM  = r_sum;
  assign FILL = r_fill;
  assign VLD  = (r_fill == FILL_W'(DEPTH));

endmodule

`default_nettype wire

// File: tb/tb_en_delay_line.sv
// +--------------------------------------------------------------------+
// | tb_en_delay_line : directed scoreboard bench, WIDTH=16 DEPTH=4     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_en_delay_line;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  typedef struct {
    int          step;
    logic [15:0] q;
    logic [17:0] sum;
    logic [2:0]  fill;
    logic        vld;
    logic [15:0] tap;
  } exp_t;

  logic        clk;
  logic        CLR;
  logic        EN;
  logic        FLUSH;
  logic [15:0] D;
  logic [1:0]  TAP_SEL;
  logic [15:0] Q;
  logic [15:0] TAP;
  logic [17:0] SUM;
  logic [2:0]  FILL;
  logic        VLD;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;
  bit   done     = 0;

  en_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .CLR     (CLR),
    .EN      (EN),
    .FLUSH   (FLUSH),
    .D       (D),
    .TAP_SEL (TAP_SEL),
    .Q       (Q),
    .TAP     (TAP),
    .SUM     (SUM),
    .FILL    (FILL),
    .VLD     (VLD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: actual %0h required %0h", name, step, act, req);
    end
  endtask

  // Monitor: the DUT presents a new result after every edge; compare it.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("Q",    e.step, 32'(Q),    32'(e.q));
      chk("SUM",  e.step, 32'(SUM),  32'(e.sum));
      chk("FILL", e.step, 32'(FILL), 32'(e.fill));
      chk("VLD",  e.step, 32'(VLD),  32'(e.vld));
      chk("TAP",  e.step, 32'(TAP),  32'(e.tap));
    end
  end

  // Drive one edge's inputs and queue the outputs expected after that edge.
  task automatic cyc(input bit clr, input bit flush, input bit en, input logic [15:0] d,
                     input logic [1:0] sel, input int eq, input int esum, input int efill,
                     input int etap);
    exp_t e;
    @(negedge clk);
    CLR = clr; FLUSH = flush; EN = en; D = d; TAP_SEL = sel;
    e.step = step_no;
    e.q    = 16'(eq);
    e.sum  = 18'(esum);
    e.fill = 3'(efill);
    e.vld  = (efill == DEPTH);
    e.tap  = 16'(etap);
    exp_q.push_back(e);
    step_no++;
  endtask

  // Samples 1..5 with 'gaps' idle cycles after each; hand-computed results.
  task automatic run_stream(input int gaps);
    int q_tab[5]    = '{0, 0, 0, 1, 2};
    int sum_tab[5]  = '{1, 3, 6, 10, 14};
    int fill_tab[5] = '{1, 2, 3, 4, 4};
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 16'(i + 1), 2'd0, q_tab[i], sum_tab[i], fill_tab[i], i + 1);
      for (int g = 0; g < gaps; g++) begin
        // Stage g holds sample (i+1-g) once that many samples have entered.
        cyc(0, 0, 0, 16'($urandom), 2'(g), q_tab[i], sum_tab[i], fill_tab[i],
            (i + 1 - g >= 1) ? (i + 1 - g) : 0);
      end
    end
  endtask

  initial begin
    CLR = 1'b1; FLUSH = 1'b0; EN = 1'b0; D = '0; TAP_SEL = '0;

    // Reset with random data/enable.
    for (int i = 0; i < 2; i++)
      cyc(1, 1'($urandom), 1'($urandom), 16'($urandom), 2'($urandom), 0, 0, 0, 0);

    // Fill with no gaps, then a short hold.
    run_stream(0);
    cyc(0, 0, 0, 16'h1234, 2'd1, 2, 14, 4, 4);
    cyc(0, 0, 0, 16'h4321, 2'd3, 2, 14, 4, 2);

    // Same stream with enable gaps.
    cyc(1, 0, 0, 16'h0, 2'd0, 0, 0, 0, 0);
    run_stream(3);

    // Signed extremes.
    cyc(1, 0, 0, 16'h0, 2'd0, 0, 0, 0, 0);
    cyc(0, 0, 1, 16'h8000, 2'd0, 0,       -32768,  1, -32768);
    cyc(0, 0, 1, 16'h8000, 2'd1, 0,       -65536,  2, -32768);
    cyc(0, 0, 1, 16'h8000, 2'd2, 0,       -98304,  3, -32768);
    cyc(0, 0, 1, 16'h8000, 2'd3, -32768,  -131072, 4, -32768);
    cyc(0, 0, 1, 16'h7fff, 2'd0, -32768,  -65537,  4, 32767);
    cyc(0, 0, 1, 16'h7fff, 2'd1, -32768,  -2,      4, 32767);
    cyc(0, 0, 1, 16'h7fff, 2'd3, -32768,  65533,   4, -32768);
    cyc(0, 0, 1, 16'h7fff, 2'd3, 32767,   131068,  4, 32767);

    // Flush wins over enable; 7 must not be stored.
    cyc(0, 1, 1, 16'd7, 2'd0, 0, 0, 0, 0);
    cyc(0, 0, 0, 16'd3, 2'd0, 0, 0, 0, 0);
    cyc(0, 0, 0, 16'd3, 2'd3, 0, 0, 0, 0);
    cyc(0, 0, 1, 16'd9, 2'd0, 0, 9, 1, 9);

    // CLR wins over FLUSH and EN mid-fill.
    cyc(0, 0, 1, 16'd10, 2'd1, 0, 19, 2, 9);
    cyc(1, 1, 1, 16'd11, 2'd0, 0, 0, 0, 0);
    cyc(0, 0, 1, 16'd12, 2'd0, 0, 12, 1, 12);
    cyc(0, 0, 0, 16'd0, 2'd1, 0, 12, 1, 0);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: actual %0d pending required 0", exp_q.size());
    end
    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog");
    end
  end

endmodule

`default_nettype wire
